// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU definitions: the ALU opcode encoding and the state type of the
// HI/LO multiply/divide unit.
// No ports (package).
package cpu_pkg;

    typedef enum logic [6:0] {
        DIV   = 7'd7,
        DIVU  = 7'd8,
        MFHI  = 7'd9,
        MFLO  = 7'd10,
        MTHI  = 7'd11,
        MTLO  = 7'd12,
        MULT  = 7'd13,
        MULTU = 7'd14
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // True for the opcodes that need the multi-cycle datapath.
    function automatic logic is_muldiv_op(opcode_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if
// Request/response bundle between the ALU/control (master) and the HI/LO
// multiply/divide unit (slave).
//   start, op, a, b : request from master
//   busy, done      : status from unit
//   hi, lo          : architectural HI/LO registers, read directly by MFHI/MFLO
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import cpu_pkg::*;

    logic             start;
    opcode_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational radix-2 iteration shared by multiply and divide.
//   part_in  : {upper, lower} partial value.
//              multiply: upper = running high product, lower = multiplier bits
//              divide  : upper = partial remainder,    lower = dividend/quotient
//   operand  : multiplicand (multiply) or divisor (divide)
//   is_div   : selects restoring-divide step instead of shift-add step
//   part_out : next partial value (divide leaves the new quotient LSB at 0)
//   q_bit    : quotient bit produced by a divide step, 0 for multiply
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] part_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] part_out,
    output logic               q_bit
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The remainder is always below the divisor, so when the trial
    // subtraction succeeds the difference fits in WIDTH bits and the
    // modulo-2^WIDTH subtraction is exact.
    always_comb begin
        upper    = part_in[2*WIDTH-1:WIDTH];
        lower    = part_in[WIDTH-1:0];
        sum      = {1'b0, upper} + (lower[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted  = {upper, lower[WIDTH-1]};
        diff     = shifted[WIDTH-1:0] - operand;
        q_bit    = 1'b0;
        part_out = '0;
        if (is_div) begin
            q_bit    = (shifted >= {1'b0, operand});
            part_out = {(q_bit ? diff : shifted[WIDTH-1:0]), lower[WIDTH-2:0], 1'b0};
        end else begin
            part_out = {sum, lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Multi-cycle responder for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns HI and LO.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hilo_muldiv_unit_if.slave (start/op/a/b in, busy/done/hi/lo out)
// Signed operations run on magnitudes and the sign is restored in FIX.
// Optional: define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a
// single-cycle multiplier (IDLE -> FIX); divides stay iterative.
module hilo_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    hilo_muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] part;
    logic [2*WIDTH-1:0] step_part;
    logic               step_q;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               is_signed;
    logic               sign_q;
    logic               sign_r;
    logic               div_zero;

    logic               start_signed;
    logic               start_div;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .part_in  (part),
        .operand  (operand),
        .is_div   (is_div),
        .part_out (step_part),
        .q_bit    (step_q)
    );

    // Request decode and operand magnitudes for signed ops.
    always_comb begin
        start_signed = (bus.op == MULT) || (bus.op == DIV);
        start_div    = (bus.op == DIV) || (bus.op == DIVU);
        a_abs        = (start_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_abs        = (start_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // Final result: sign restore, plus the divide-by-zero override which
    // reports the raw dividend rather than its magnitude.
    always_comb begin
        prod = part;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) begin
            prod = {{WIDTH{1'b0}}, operand} * {{WIDTH{1'b0}}, part[WIDTH-1:0]};
        end
`endif
        quo = part[WIDTH-1:0];
        rem = part[2*WIDTH-1:WIDTH];
        if (is_signed && sign_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (is_signed && sign_r) begin
            rem = -rem;
        end
        if (!is_div) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    // Control FSM with registered busy/done and the HI/LO registers.
    // Multiply keeps the multiplicand in operand and the multiplier in the
    // low half of part; divide keeps the divisor in operand and the dividend
    // in the low half of part, which fills with quotient bits as it shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            part      <= '0;
            operand   <= '0;
            a_raw     <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            div_zero  <= 1'b0;
            bus.hi    <= '0;
            bus.lo    <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_muldiv_op(bus.op)) begin
                            is_div    <= start_div;
                            is_signed <= start_signed;
                            sign_q    <= start_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            sign_r    <= start_signed & bus.a[WIDTH-1];
                            div_zero  <= (bus.b == '0);
                            a_raw     <= bus.a;
                            count     <= '0;
                            bus.busy  <= 1'b1;
                            if (start_div) begin
                                operand <= b_abs;
                                part    <= {{WIDTH{1'b0}}, a_abs};
                            end else begin
                                operand <= a_abs;
                                part    <= {{WIDTH{1'b0}}, b_abs};
                            end
`ifdef MULDIV_FAST_MUL_EN
                            state <= start_div ? RUN : FIX;
`else
                            state <= RUN;
`endif
                        end else if (bus.op == MTHI) begin
                            bus.hi   <= bus.a;
                            bus.done <= 1'b1;
                        end else if (bus.op == MTLO) begin
                            bus.lo   <= bus.a;
                            bus.done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The step leaves the quotient LSB clear; fold it in here.
                    part  <= {step_part[2*WIDTH-1:1], step_part[0] | step_q};
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.hi   <= fix_hi;
                    bus.lo   <= fix_lo;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
// Self-checking bench for hilo_muldiv_unit. A transaction-level model
// computes HI/LO results with plain arithmetic and tracks latency; a monitor
// compares busy/done/hi/lo against it on every falling edge. Directed tests
// additionally pin results to hand-computed constants.
module tb_hilo_muldiv_unit;
    import cpu_pkg::*;

    localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus();

    hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Architectural result {hi, lo} from the ISA rules.
    function automatic logic [63:0] model_result(opcode_t o, logic [31:0] av, logic [31:0] bv);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa;
        int                 sb;
        logic [31:0]        rq;
        logic [31:0]        rr;
        sa = av;
        sb = bv;
        case (o)
            MULT: begin
                sp = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
                return sp;
            end
            MULTU: begin
                up = {32'b0, av} * {32'b0, bv};
                return up;
            end
            DIV: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                rq = sa / sb;
                rr = sa % sb;
                return {rr, rq};
            end
            DIVU: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                rq = av / bv;
                rr = av % bv;
                return {rr, rq};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Transaction model: accepts requests only when idle, delivers the
    // result after the operation's latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (bus.start) begin
                case (bus.op)
                    MTHI: begin
                        m_hi   <= bus.a;
                        m_done <= 1'b1;
                    end
                    MTLO: begin
                        m_lo   <= bus.a;
                        m_done <= 1'b1;
                    end
                    MULT, MULTU: begin
                        m_pend <= model_result(bus.op, bus.a, bus.b);
                        m_left <= MUL_LAT;
                        m_busy <= 1'b1;
                    end
                    DIV, DIVU: begin
                        m_pend <= model_result(bus.op, bus.a, bus.b);
                        m_left <= DIV_LAT;
                        m_busy <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        checkOutput("mon_busy", 64'(bus.busy), 64'(m_busy));
        checkOutput("mon_done", 64'(bus.done), 64'(m_done));
        checkOutput("mon_hi", 64'(bus.hi), 64'(m_hi));
        checkOutput("mon_lo", 64'(bus.lo), 64'(m_lo));
    end

    task automatic applyStimulus(opcode_t o, logic [31:0] av, logic [31:0] bv);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles; optionally pokes new
    // requests while the operation is in flight.
    task automatic waitDone(int poke, output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.done) seen = 1'b1;
            if (poke >= 0) begin
                if (i == poke) begin
                    bus.start = 1'b1;
                    bus.op    = MTHI;
                    bus.a     = 32'hDEAD_BEEF;
                end else if (i == poke + 1) begin
                    bus.op = MULTU;
                    bus.a  = 32'd3;
                    bus.b  = 32'd3;
                end else if (i == poke + 2) begin
                    bus.start = 1'b0;
                end
            end
        end
    endtask

    task automatic runOp(string name, opcode_t o, logic [31:0] av, logic [31:0] bv,
                         logic [31:0] eh, logic [31:0] el, int exp_busy, int poke);
        int bc;
        bit seen;
        applyStimulus(o, av, bv);
        waitDone(poke, bc, seen);
        checkOutput({name, " done"}, 64'(seen), 64'd1);
        checkOutput({name, " busy_cycles"}, 64'(bc), 64'(exp_busy));
        checkOutput({name, " hi"}, 64'(bus.hi), 64'(eh));
        checkOutput({name, " lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_count;
        bus.start = 1'b0;
        bus.op    = MFHI;
        bus.a     = '0;
        bus.b     = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset hi", 64'(bus.hi), 64'd0);
        checkOutput("reset lo", 64'(bus.lo), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        runOp("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, -1);
        runOp("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, -1);
        runOp("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, -1);
        runOp("div_negdivisor", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT, -1);
        runOp("divu_zero", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DIV_LAT, -1);
        runOp("div_zero_neg", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, -1);
        runOp("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, -1);

        // Back-to-back MTHI then MTLO.
        bus.start = 1'b1;
        bus.op    = MTHI;
        bus.a     = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.op = MTLO;
        bus.a  = 32'h9ABC_DEF0;
        @(negedge clk);
        checkOutput("mthi done", 64'(bus.done), 64'd1);
        checkOutput("mthi busy", 64'(bus.busy), 64'd0);
        checkOutput("mthi hi", 64'(bus.hi), 64'h1234_5678);
        checkOutput("mthi lo_kept", 64'(bus.lo), 64'h8000_0000);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        checkOutput("mtlo done", 64'(bus.done), 64'd1);
        checkOutput("mtlo busy", 64'(bus.busy), 64'd0);
        checkOutput("mtlo hi_kept", 64'(bus.hi), 64'h1234_5678);
        checkOutput("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
        @(negedge clk);
        checkOutput("mtlo done_cleared", 64'(bus.done), 64'd0);

        // Requests with non-HI/LO opcodes are ignored.
        bus.start = 1'b1;
        bus.op    = MFHI;
        bus.a     = 32'h5555_5555;
        @(posedge clk);
        #1 bus.op = opcode_t'(7'd3);
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_count = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_count++;
        end
        checkOutput("badop no_done", 64'(done_count), 64'd0);
        checkOutput("badop hi", 64'(bus.hi), 64'h1234_5678);
        checkOutput("badop lo", 64'(bus.lo), 64'h9ABC_DEF0);

        // DIVU with MTHI/MULTU requests poked while busy: they must be ignored.
        runOp("divu_poked", DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, DIV_LAT, 5);

        // Reset in the middle of a divide aborts it without a done.
        applyStimulus(DIVU, 32'd50, 32'd5);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort hi", 64'(bus.hi), 64'd0);
        checkOutput("abort lo", 64'(bus.lo), 64'd0);
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        checkOutput("abort done", 64'(bus.done), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        done_count = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_count++;
        end
        checkOutput("abort no_done", 64'(done_count), 64'd0);

        runOp("multu_small", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT, -1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
